// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and FSM state encodings for the memory responder.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WRITE = 2'd1,
        W_RESP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/mem_sp_bytewe.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register only updates on read cycles, so writes never disturb a pending read result.
module mem_sp_bytewe #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [DATA_W/8-1:0]            be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end else begin
                rdata <= mem_q[addr];
            end
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite responder over a byte-writable single-port RAM; independent read/write FSMs, writes win the port.
// Optional build macro AXIL_MEM_MISALIGN_ERR_EN: unaligned addresses are rejected with SLVERR.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 64,
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    input  logic [2:0]          arprot_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [2:0]          awprot_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

    // Returns {miss, word index}.
    function automatic logic [IDX_W:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        logic              miss;
        off  = addr - BASE_ADDR;
        miss = (addr < BASE_ADDR) || ((off >> LSB) >= ADDR_W'(DEPTH_WORDS));
`ifdef AXIL_MEM_MISALIGN_ERR_EN
        miss = miss || (addr[LSB-1:0] != '0);
`endif
        return {miss, off[LSB +: IDX_W]};
    endfunction

    rd_state_e          rd_state_q, rd_state_d;
    wr_state_e          wr_state_q, wr_state_d;
    logic               live_q;
    logic               aw_got_q, aw_got_d;
    logic               w_got_q, w_got_d;
    logic               ar_hs, aw_hs, w_hs;

    logic [IDX_W-1:0]   rd_idx_q, wr_idx_q;
    logic               rd_err_q, wr_err_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [STRB_W-1:0]  wstrb_q;

    logic               ram_en, ram_we, wr_owns;
    logic [STRB_W-1:0]  ram_be;
    logic [IDX_W-1:0]   ram_addr;
    logic [DATA_W-1:0]  ram_rdata;

    logic               unused_prot;
    assign unused_prot = ^{arprot_i, awprot_i};

    // live_q holds the readies low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= 1'b0;
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) {rd_err_q, rd_idx_q} <= decode(araddr_i);
        if (aw_hs) {wr_err_q, wr_idx_q} <= decode(awaddr_i);
        if (w_hs) begin
            wdata_q <= wdata_i;
            wstrb_q <= wstrb_i;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_o  = 1'b0;
        rvalid_o   = 1'b0;
        rdata_o    = '0;
        rresp_o    = OKAY;
        ar_hs      = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                arready_o = live_q;
                ar_hs     = arvalid_i && live_q;
                if (ar_hs) rd_state_d = R_READ;
            end
            R_READ: begin
                if (!wr_owns) rd_state_d = R_RESP;
            end
            R_RESP: begin
                rvalid_o = 1'b1;
                rresp_o  = rd_err_q ? SLVERR : OKAY;
                rdata_o  = rd_err_q ? '0 : ram_rdata;
                if (rready_i) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awready_o  = 1'b0;
        wready_o   = 1'b0;
        bvalid_o   = 1'b0;
        bresp_o    = OKAY;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                awready_o = live_q && !aw_got_q;
                wready_o  = live_q && !w_got_q;
                aw_hs     = awvalid_i && awready_o;
                w_hs      = wvalid_i && wready_o;
                aw_got_d  = aw_got_q || aw_hs;
                w_got_d   = w_got_q || w_hs;
                if (aw_got_d && w_got_d) begin
                    wr_state_d = W_WRITE;
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                end
            end
            W_WRITE: wr_state_d = W_RESP;
            W_RESP: begin
                bvalid_o = 1'b1;
                bresp_o  = wr_err_q ? SLVERR : OKAY;
                if (bready_i) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // The write cycle owns the port even on a miss, so a colliding read always waits one cycle.
    assign wr_owns = (wr_state_q == W_WRITE);

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_be   = '0;
        ram_addr = rd_idx_q;
        if (wr_owns) begin
            ram_en   = !wr_err_q;
            ram_we   = 1'b1;
            ram_be   = wstrb_q;
            ram_addr = wr_idx_q;
        end else if (rd_state_q == R_READ) begin
            ram_en = !rd_err_q;
        end
    end

    mem_sp_bytewe #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave with a word-array memory model and a per-cycle response checker.
// Expectations for the unaligned read follow the AXIL_MEM_MISALIGN_ERR_EN build macro.
module tb_axi_lite_mem_slave;

    localparam logic [63:0] BASE  = 64'h0;
    localparam int unsigned DEPTH = 1024;

    logic        clk, rst;
    logic [63:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [7:0]  wstrb;
    logic [1:0]  rresp, bresp;
    logic [2:0]  arprot, awprot;

    axi_lite_mem_slave #(
        .ADDR_W      (64),
        .DATA_W      (64),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .arprot_i  (arprot),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .awprot_i  (awprot),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_r[$];
    exp_t        exp_b[$];
    logic [63:0] mdl [int unsigned];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [63:0] a);
        if (a < BASE) return 1'b0;
        if ((a - BASE) / 8 >= 64'(DEPTH)) return 1'b0;
`ifdef AXIL_MEM_MISALIGN_ERR_EN
        if (a % 8 != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic int unsigned widx(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    // Response checker: every cycle a valid is up it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (exp_r.size() == 0) chk("r_spurious_valid", 1, 0);
            else begin
                chk("r_data", rdata, exp_r[0].data);
                chk("r_resp", {62'd0, rresp}, {62'd0, exp_r[0].resp});
                if (rready) void'(exp_r.pop_front());
            end
        end
        if (!rst && bvalid) begin
            if (exp_b.size() == 0) chk("b_spurious_valid", 1, 0);
            else begin
                chk("b_resp", {62'd0, bresp}, {62'd0, exp_b[0].resp});
                if (bready) void'(exp_b.pop_front());
            end
        end
    end

    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int w_lead, input bit hold_b, output logic [1:0] got_resp);
        int          n;
        bit          aw_hs, w_hs, aw_done, w_done;
        exp_t        e;
        logic [63:0] w;
        if (model_hit(a)) begin
            w = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'h0;
            for (int i = 0; i < 8; i++) if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
            mdl[widx(a)] = w;
        end
        e.data = 64'h0;
        e.resp = model_hit(a) ? 2'b00 : 2'b10;
        exp_b.push_back(e);
        @(posedge clk); #1;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        bready = !hold_b;
        if (w_lead == 0) begin
            awaddr  = a;
            awvalid = 1'b1;
        end
        n = 0; aw_done = 1'b0; w_done = 1'b0;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (!aw_done && !awvalid && n >= w_lead) begin
                awaddr  = a;
                awvalid = 1'b1;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("aw_w_handshake_timeout", 0, 1);
        n = 1;
        while (n < 50) begin
            @(negedge clk);
            if (bvalid) break;
            n++;
            @(posedge clk); #1;
        end
        got_resp = bresp;
        chk("b_latency", 64'(n), 64'd2);
        if (!hold_b) begin
            @(posedge clk); #1;
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [63:0] a, input int hold, input int exp_lat,
                            output logic [63:0] got, output logic [1:0] got_resp);
        int   n;
        bit   done;
        exp_t e;
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        rready  = (hold == 0);
        n = 0; done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = arvalid && arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!done) chk("ar_handshake_timeout", 0, 1);
        e.resp = model_hit(a) ? 2'b00 : 2'b10;
        e.data = model_hit(a) ? mdl[widx(a)] : 64'h0;
        exp_r.push_back(e);
        n = 1;
        while (n < 50) begin
            @(negedge clk);
            if (rvalid) break;
            n++;
            @(posedge clk); #1;
        end
        got      = rdata;
        got_resp = rresp;
        chk("r_latency", 64'(n), 64'(exp_lat));
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk("r_valid_held", {63'd0, rvalid}, 64'd1);
            chk("r_data_held", rdata, got);
            rready = 1'b1;
        end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        logic [1:0]  resp;
        logic [1:0]  bresp_got;

        rst = 1'b1;
        araddr = '0; arvalid = 0; rready = 0; arprot = '0;
        awaddr = '0; awvalid = 0; awprot = '0;
        wdata = '0; wstrb = '0; wvalid = 0; bready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", {63'd0, arready}, 64'd0);
        chk("rst_awready", {63'd0, awready}, 64'd0);
        chk("rst_wready",  {63'd0, wready},  64'd0);
        chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
        chk("rst_bvalid",  {63'd0, bvalid},  64'd0);
        chk("rst_rdata",   rdata, 64'd0);
        chk("rst_rresp",   {62'd0, rresp}, 64'd0);
        chk("rst_bresp",   {62'd0, bresp}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arready_before_edge", {63'd0, arready}, 64'd0);
        @(posedge clk); #1;
        chk("idle_arready", {63'd0, arready}, 64'd1);
        chk("idle_awready", {63'd0, awready}, 64'd1);
        chk("idle_wready",  {63'd0, wready},  64'd1);
        chk("idle_rvalid",  {63'd0, rvalid},  64'd0);
        chk("idle_bvalid",  {63'd0, bvalid},  64'd0);

        // Full-word write and readback.
        axi_write(64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 1'b0, bresp_got);
        chk("wr10_bresp", {62'd0, bresp_got}, 64'd0);
        axi_read(64'h10, 0, 2, got, resp);
        chk("rd10_data", got, 64'hDEADBEEF_CAFEF00D);
        chk("rd10_resp", {62'd0, resp}, 64'd0);

        // W three cycles ahead of AW, low-lane strobe over an all-ones word.
        axi_write(64'h18, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, 1'b0, bresp_got);
        axi_write(64'h18, 64'h11111111_22222222, 8'h0F, 3, 1'b0, bresp_got);
        axi_read(64'h18, 0, 2, got, resp);
        chk("rd18_partial", got, 64'hFFFFFFFF_22222222);

        // Empty strobe: OKAY, word unchanged.
        axi_write(64'h18, 64'h0, 8'h00, 0, 1'b0, bresp_got);
        chk("wstrb0_bresp", {62'd0, bresp_got}, 64'd0);
        axi_read(64'h18, 0, 2, got, resp);
        chk("wstrb0_data", got, 64'hFFFFFFFF_22222222);

        // Out of range just past the last word; index would alias word 0.
        axi_write(64'h0, 64'h01234567_89ABCDEF, 8'hFF, 0, 1'b0, bresp_got);
        axi_read(BASE + 64'(DEPTH) * 8, 0, 2, got, resp);
        chk("oor_rdata", got, 64'd0);
        chk("oor_rresp", {62'd0, resp}, 64'd2);
        axi_write(BASE + 64'(DEPTH) * 8, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, 1'b0, bresp_got);
        chk("oor_bresp", {62'd0, bresp_got}, 64'd2);
        axi_read(64'h0, 0, 2, got, resp);
        chk("oor_word0_untouched", got, 64'h01234567_89ABCDEF);

        // Read collides with the write cycle; rready held low four cycles.
        axi_write(64'h20, 64'h0, 8'hFF, 0, 1'b0, bresp_got);
        fork
            axi_write(64'h20, 64'h5, 8'hFF, 0, 1'b0, bresp_got);
            axi_read(64'h20, 4, 3, got, resp);
        join
        chk("collide_data", got, 64'h5);
        chk("collide_resp", {62'd0, resp}, 64'd0);

        // Unaligned read.
        axi_read(64'h13, 0, 2, got, resp);
`ifdef AXIL_MEM_MISALIGN_ERR_EN
        chk("misalign_resp", {62'd0, resp}, 64'd2);
        chk("misalign_data", got, 64'd0);
`else
        chk("misalign_resp", {62'd0, resp}, 64'd0);
        chk("misalign_data", got, 64'hDEADBEEF_CAFEF00D);
`endif

        // Reset while the write response is pending.
        axi_write(64'h28, 64'h77, 8'hFF, 0, 1'b1, bresp_got);
        #1 rst = 1'b1;
        #1;
        chk("reset_drops_bvalid", {63'd0, bvalid}, 64'd0);
        exp_b.delete();
        @(posedge clk); #1;
        chk("reset_awready", {63'd0, awready}, 64'd0);
        chk("reset_arready", {63'd0, arready}, 64'd0);
        rst    = 1'b0;
        bready = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_awready", {63'd0, awready}, 64'd1);
        chk("post_reset_bvalid",  {63'd0, bvalid},  64'd0);
        axi_read(64'h10, 0, 2, got, resp);
        chk("ram_survives_reset", got, 64'hDEADBEEF_CAFEF00D);
        axi_read(64'h28, 0, 2, got, resp);
        chk("write_before_reset", got, 64'h77);

        repeat (3) @(posedge clk);
        chk("r_queue_drained", 64'(exp_r.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
